updown_counter_param: RTL and testbench

Parametrised up/down counter, successor to the fixed 4-bit load/enable counter.
- Generalised width and programmable modulus (terminal value MAX_VAL).
- Runtime step size and wrap/saturate mode select.
- Registered terminal-count pulse plus sticky overflow/underflow flags.
- Used as the standard timing/event counter in the control-elements library.

---
 rtl/counter_pkg.sv | 57 +++++
 rtl/counter_prescaler.sv | 27 ++
 rtl/updown_counter_param.sv | 99 +++++++++
 tb/tb_updown_counter_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types, mode constants and next-count function for the up/down counter.
package counter_pkg;

    localparam int unsigned CNT_MAX_W = 32;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] count;
        logic                 tc;
        logic                 ovf;
        logic                 udf;
    } cnt_res_t;

    // Next count and event bits; s must already be clamped to max_val.
    function automatic cnt_res_t cnt_next(
        input logic [CNT_MAX_W-1:0] count,
        input logic [CNT_MAX_W-1:0] s,
        input logic                 up,
        input logic                 mode,
        input logic [CNT_MAX_W-1:0] max_val
    );
        cnt_res_t           res;
        logic [CNT_MAX_W:0] w_sum;
        logic [CNT_MAX_W:0] w_lim;
        res.count = count;
        res.tc    = 1'b0;
        res.ovf   = 1'b0;
        res.udf   = 1'b0;
        w_sum     = {1'b0, count} + {1'b0, s};
        w_lim     = {1'b0, max_val} + (CNT_MAX_W+1)'(1);
        if (s != '0) begin
            if (up) begin
                if (w_sum > {1'b0, max_val}) begin
                    res.tc    = 1'b1;
                    res.ovf   = 1'b1;
                    res.count = (mode == MODE_WRAP) ? CNT_MAX_W'(w_sum - w_lim) : max_val;
                end else begin
                    res.count = CNT_MAX_W'(w_sum);
                end
            end else begin
                if (count >= s) begin
                    res.count = count - s;
                end else begin
                    res.tc    = 1'b1;
                    res.udf   = 1'b1;
                    res.count = (mode == MODE_WRAP)
                              ? CNT_MAX_W'(w_lim + {1'b0, count} - {1'b0, s})
                              : '0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider: tick is high on the enabled cycle that ends each PRESCALE-cycle phase.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate, tc pulse and sticky flags.
// Optional clock-enable prescaler selected by COUNTER_PRESCALE_EN.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_in,
    input  logic             enable,
    input  logic             up,
    input  logic [WIDTH-1:0] step_in,
    input  logic             wrap_mode,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             ovf_flag,
    output logic             udf_flag
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_udf;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_val;
    logic             w_tick;
    logic             w_adv;
    cnt_res_t         w_res;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic             w_udf_nxt;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (enable),
        .tick  (w_tick)
    );
`else
    // An illegal PRESCALE of 0 disables counting rather than being silently accepted.
    localparam logic PRESCALE_OK = (PRESCALE >= 1);
    assign w_tick = PRESCALE_OK;
`endif

    assign w_adv      = enable & w_tick;
    assign w_step     = (step_in > MAX_W) ? MAX_W : step_in;
    assign w_load_val = (load_in > MAX_W) ? MAX_W : load_in;
    assign w_res      = cnt_next(CNT_MAX_W'(r_count), CNT_MAX_W'(w_step), up, wrap_mode,
                                 CNT_MAX_W'(MAX_VAL));

    // Next-state: load beats counting; a new event beats clr_flags.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_ovf_nxt   = r_ovf & ~clr_flags;
        w_udf_nxt   = r_udf & ~clr_flags;
        if (load) begin
            w_count_nxt = w_load_val;
        end else if (w_adv) begin
            w_count_nxt = WIDTH'(w_res.count);
            w_tc_nxt    = w_res.tc;
            if (w_res.ovf) w_ovf_nxt = 1'b1;
            if (w_res.udf) w_udf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
        end
    end

    assign count_out = r_count;
    assign tc        = r_tc;
    assign ovf_flag  = r_ovf;
    assign udf_flag  = r_udf;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param (WIDTH=4, MAX_VAL=9, PRESCALE=3).
module tb_updown_counter_param;

    localparam int WIDTH    = 4;
    localparam int MAX_VAL  = 9;
    localparam int PRESCALE = 3;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_in;
    logic             enable;
    logic             up;
    logic [WIDTH-1:0] step_in;
    logic             wrap_mode;
    logic             clr_flags;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             ovf_flag;
    logic             udf_flag;

    updown_counter_param #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_in   (load_in),
        .enable    (enable),
        .up        (up),
        .step_in   (step_in),
        .wrap_mode (wrap_mode),
        .clr_flags (clr_flags),
        .count_out (count_out),
        .tc        (tc),
        .ovf_flag  (ovf_flag),
        .udf_flag  (udf_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int tc;
        int ovf;
        int udf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_cnt = 0;
    int m_ovf = 0;
    int m_udf = 0;
    int m_pre = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, advance the reference model, then compare registered outputs.
    task automatic cyc(input bit rst, input bit ld, input int ldv, input bit en,
                       input bit u, input int st, input bit wm, input bit clr);
        exp_t e;
        exp_t got;
        int   s;
        int   t;
        bit   adv;
        @(negedge clk);
        reset     = rst;
        load      = ld;
        load_in   = 4'(ldv);
        enable    = en;
        up        = u;
        step_in   = 4'(st);
        wrap_mode = wm;
        clr_flags = clr;
        e.tc = 0;
        if (rst) begin
            m_cnt = 0; m_ovf = 0; m_udf = 0; m_pre = 0;
        end else begin
            adv = en;
`ifdef COUNTER_PRESCALE_EN
            adv = en && (m_pre == PRESCALE - 1);
            if (ld) m_pre = 0;
            else if (en) m_pre = (m_pre == PRESCALE - 1) ? 0 : m_pre + 1;
`endif
            if (clr) begin
                m_ovf = 0;
                m_udf = 0;
            end
            if (ld) begin
                m_cnt = (ldv > MAX_VAL) ? MAX_VAL : ldv;
            end else if (adv) begin
                s = (st > MAX_VAL) ? MAX_VAL : st;
                if (s != 0) begin
                    if (u) begin
                        t = m_cnt + s;
                        if (t > MAX_VAL) begin
                            m_cnt = wm ? t - (MAX_VAL + 1) : MAX_VAL;
                            e.tc = 1;
                            m_ovf = 1;
                        end else begin
                            m_cnt = t;
                        end
                    end else if (m_cnt >= s) begin
                        m_cnt = m_cnt - s;
                    end else begin
                        m_cnt = wm ? m_cnt + MAX_VAL + 1 - s : 0;
                        e.tc = 1;
                        m_udf = 1;
                    end
                end
            end
        end
        e.cnt = m_cnt;
        e.ovf = m_ovf;
        e.udf = m_udf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("count", int'(count_out), got.cnt);
        chk("tc",    int'(tc),        got.tc);
        chk("ovf",   int'(ovf_flag),  got.ovf);
        chk("udf",   int'(udf_flag),  got.udf);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_in = '0; enable = 1'b0; up = 1'b1;
        step_in = '0; wrap_mode = 1'b0; clr_flags = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        chk("rst_count", int'(count_out), 0);

        // Decade wrap
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1, 1, 1, 0);
`ifndef COUNTER_PRESCALE_EN
        chk("t1_count", int'(count_out), 0);
        chk("t1_ovf",   int'(ovf_flag),  1);
`endif

        // Saturate with step, up then down
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 4, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 3, 0, 0);
`ifndef COUNTER_PRESCALE_EN
        chk("t2_udf", int'(udf_flag), 1);
        chk("t2_tc",  int'(tc),       1);
`endif

        // Load priority and clamp
        cyc(0, 1, 15, 1, 1, 1, 1, 0);
        chk("t3_clamp", int'(count_out), 9);
        cyc(0, 1, 3, 1, 1, 1, 1, 0);
        chk("t3_load", int'(count_out), 3);

        // Down wrap with large step, then clear flags
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 5, 1, 0);
`ifndef COUNTER_PRESCALE_EN
        chk("t4_count", int'(count_out), 7);
`endif
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("t4_clr", int'(udf_flag), 0);

        // Reset mid-run with load asserted
        cyc(0, 1, 8, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 4, 1, 0);
        cyc(0, 0, 0, 1, 1, 4, 1, 0);
        cyc(1, 1, 5, 1, 1, 4, 1, 0);
        chk("t5_count", int'(count_out), 0);

`ifdef COUNTER_PRESCALE_EN
        // Prescaled phase: enable gaps hold the phase, load restarts it
        cyc(1, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 1, 1, 0);
        chk("t6_first", int'(count_out), 1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 1, 1, 0);
        chk("t6_hold", int'(count_out), 2);
        cyc(0, 0, 0, 1, 1, 1, 1, 0);
        cyc(0, 1, 5, 1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 1, 1, 0);
`endif

        // Randomised mix
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(49) == 0), ($urandom_range(9) == 0), int'($urandom_range(15)),
                ($urandom_range(3) != 0), 1'($urandom_range(1)), int'($urandom_range(15)),
                1'($urandom_range(1)), ($urandom_range(7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
